// File: rtl/multicycle_controlunit.sv
// Multi-cycle RV32I-subset control FSM: owns the instruction register, sequences
// FETCH/DECODE/EXEC/MEM/WB over a ready-handshaked memory port, traps on bad opcode or memory timeout.
module multicycle_controlunit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  input  logic             eq,
  output logic [31:0]      instr,
  output logic             mem_req,
  output logic             mem_we,
  output logic             regwrite,
  output logic [2:0]       aluctrl,
  output logic             alu_sub,
  output logic             alusrc,
  output logic [2:0]       immsrc,
  output logic             pcsrc,
  output logic             pc_we,
  output logic [1:0]       resultsrc,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(MEM_TIMEOUT);

  localparam logic [6:0] OP_ALUI = 7'd19;
  localparam logic [6:0] OP_ALUR = 7'd51;
  localparam logic [6:0] OP_LOAD = 7'd3;
  localparam logic [6:0] OP_STORE = 7'd35;
  localparam logic [6:0] OP_BR   = 7'd99;
  localparam logic [6:0] OP_JAL  = 7'd111;
  localparam logic [6:0] OP_LUI  = 7'd55;

  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic [TW-1:0]     wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [6:0] opcode;
  logic [2:0] f3;
  assign opcode = instr_q[6:0];
  assign f3     = instr_q[14:12];

  // Raw control decode from registered state + instruction.
  logic       mem_req_c, mem_we_c, regwrite_c, alu_sub_c, alusrc_c, pcsrc_c, pc_we_c;
  logic [2:0] aluctrl_c, immsrc_c;
  logic [1:0] resultsrc_c;

  always_comb begin
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    regwrite_c  = 1'b0;
    aluctrl_c   = 3'b000;
    alu_sub_c   = 1'b0;
    alusrc_c    = 1'b0;
    immsrc_c    = 3'b000;
    pcsrc_c     = 1'b0;
    pc_we_c     = 1'b0;
    resultsrc_c = 2'b00;
    case (state_q)
      S_FETCH: mem_req_c = 1'b1;
      S_EXEC: begin
        case (opcode)
          OP_ALUI: begin aluctrl_c = f3; alusrc_c = 1'b1; end
          OP_ALUR: begin aluctrl_c = f3; alu_sub_c = instr_q[30]; end
          OP_LOAD: alusrc_c = 1'b1;
          OP_STORE: begin alusrc_c = 1'b1; immsrc_c = 3'b001; end
          OP_BR: begin
            aluctrl_c = 3'b111;
            immsrc_c  = 3'b011;
            pc_we_c   = 1'b1;
            pcsrc_c   = (f3 == 3'b000) ? eq : (f3 == 3'b001) ? ~eq : 1'b0;
          end
          OP_JAL: begin
            immsrc_c = 3'b100; pcsrc_c = 1'b1; regwrite_c = 1'b1;
            resultsrc_c = 2'b10; pc_we_c = 1'b1;
          end
          OP_LUI: begin
            immsrc_c = 3'b010; regwrite_c = 1'b1; resultsrc_c = 2'b11; pc_we_c = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = (opcode == OP_STORE);
        alusrc_c  = 1'b1;
        pc_we_c   = (opcode == OP_STORE) & mem_ready;
      end
      S_WB: begin
        regwrite_c  = 1'b1;
        pc_we_c     = 1'b1;
        resultsrc_c = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  logic waiting, to_hit;
  assign waiting = mem_req_c & ~mem_ready;
  assign to_hit  = (MEM_TIMEOUT != 0) && (wcnt_q == TO_LIM) && waiting;

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    count_d   = count_q + {{(CNT_W-1){1'b0}}, pc_we_c};
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_ALUI, OP_ALUR, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_LUI: state_d = S_EXEC;
          default: begin state_d = S_TRAP; illegal_d = 1'b1; end
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_ALUI, OP_ALUR:  state_d = S_WB;
          OP_LOAD, OP_STORE: state_d = S_MEM;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = (opcode == OP_LOAD) ? S_WB : S_FETCH;
        end else if (to_hit) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase
    // Any state change restarts the wait count; it saturates at the limit.
    if (state_d != state_q)                 wcnt_d = '0;
    else if (waiting && (wcnt_q != TO_LIM)) wcnt_d = wcnt_q + 1'b1;
    else                                    wcnt_d = wcnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instr_q   <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      wcnt_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      wcnt_q    <= wcnt_d;
      count_q   <= count_d;
    end
  end

  // Gate with rst so the FETCH request is not visible while reset is held.
  assign mem_req     = mem_req_c & ~rst;
  assign mem_we      = mem_we_c & ~rst;
  assign regwrite    = regwrite_c & ~rst;
  assign aluctrl     = rst ? 3'b000 : aluctrl_c;
  assign alu_sub     = alu_sub_c & ~rst;
  assign alusrc      = alusrc_c & ~rst;
  assign immsrc      = rst ? 3'b000 : immsrc_c;
  assign pcsrc       = pcsrc_c & ~rst;
  assign pc_we       = pc_we_c & ~rst;
  assign resultsrc   = rst ? 2'b00 : resultsrc_c;
  assign instr       = instr_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Directed bench for multicycle_controlunit (MEM_TIMEOUT=4, CNT_W=3 so count wrap is reachable).
module tb_multicycle_controlunit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_rdata;
  logic        mem_ready, eq;
  logic [31:0] instr;
  logic        mem_req, mem_we, regwrite, alu_sub, alusrc, pcsrc, pc_we, illegal, timeout;
  logic [2:0]  aluctrl, immsrc, instr_count;
  logic [1:0]  resultsrc;

  int total = 0;
  int bad   = 0;

  multicycle_controlunit #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .eq(eq),
    .instr(instr), .mem_req(mem_req), .mem_we(mem_we), .regwrite(regwrite),
    .aluctrl(aluctrl), .alu_sub(alu_sub), .alusrc(alusrc), .immsrc(immsrc),
    .pcsrc(pcsrc), .pc_we(pc_we), .resultsrc(resultsrc), .illegal(illegal),
    .timeout(timeout), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [14:0] ctl_o;
  assign ctl_o = {mem_req, mem_we, regwrite, aluctrl, alu_sub, alusrc, immsrc, pcsrc, pc_we, resultsrc};

  function automatic logic [14:0] pk(input logic mreq, input logic mwe, input logic rw,
                                     input logic [2:0] alu, input logic sub, input logic asrc,
                                     input logic [2:0] imm, input logic pcs, input logic pcw,
                                     input logic [1:0] res);
    return {mreq, mwe, rw, alu, sub, asrc, imm, pcs, pcw, res};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs just after negedge, check controls, advance to next negedge.
  task automatic cyc(input string tag, input logic rdy, input logic [31:0] rd, input logic e,
                     input logic [14:0] exp);
    mem_ready = rdy; mem_rdata = rd; eq = e;
    #1;
    chk(tag, {17'b0, ctl_o}, {17'b0, exp});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch_decode(input string tag, input logic [31:0] word);
    cyc({tag, "_fetch"}, 1'b1, word, 1'b0, pk(1,0,0,3'b000,0,0,3'b000,0,0,2'b00));
    cyc({tag, "_decode"}, 1'b1, 32'hDEADBEEF, 1'b0, 15'd0);
    chk({tag, "_instr"}, instr, word);
  endtask

  task automatic chk_cnt(input string tag, input logic [2:0] exp);
    chk(tag, {29'b0, instr_count}, {29'b0, exp});
  endtask

  localparam logic [14:0] C_F      = 15'b1_0_0_000_0_0_000_0_0_00;
  localparam logic [14:0] C_WB_ALU = 15'b0_0_1_000_0_0_000_0_1_00;

  initial begin
    rst = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h0; eq = 1'b0;
    #1;
    chk("rst_ctl", {17'b0, ctl_o}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk_cnt("rst_cnt", 3'd0);
    chk("rst_flags", {30'b0, illegal, timeout}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // addi x1,x0,5
    fetch_decode("addi", 32'h00500093);
    cyc("addi_exec", 1'b0, 32'h0, 1'b0, pk(0,0,0,3'b000,0,1,3'b000,0,0,2'b00));
    cyc("addi_wb", 1'b0, 32'h0, 1'b0, C_WB_ALU);
    chk_cnt("addi_cnt", 3'd1);

    // beq taken, bne not taken with eq=1
    fetch_decode("beq", 32'h00000463);
    cyc("beq_exec", 1'b0, 32'h0, 1'b1, pk(0,0,0,3'b111,0,0,3'b011,1,1,2'b00));
    chk_cnt("beq_cnt", 3'd2);
    fetch_decode("bne", 32'h00001463);
    cyc("bne_exec", 1'b0, 32'h0, 1'b1, pk(0,0,0,3'b111,0,0,3'b011,0,1,2'b00));
    chk_cnt("bne_cnt", 3'd3);

    // lw with 3 wait cycles
    fetch_decode("lw", 32'h00002103);
    cyc("lw_exec", 1'b1, 32'h0, 1'b0, pk(0,0,0,3'b000,0,1,3'b000,0,0,2'b00));
    for (int i = 0; i < 3; i++)
      cyc("lw_memwait", 1'b0, 32'h0, 1'b0, pk(1,0,0,3'b000,0,1,3'b000,0,0,2'b00));
    cyc("lw_memrdy", 1'b1, 32'hCAFEF00D, 1'b0, pk(1,0,0,3'b000,0,1,3'b000,0,0,2'b00));
    chk("lw_instr_hold", instr, 32'h00002103);
    cyc("lw_wb", 1'b0, 32'h0, 1'b0, pk(0,0,1,3'b000,0,0,3'b000,0,1,2'b01));
    chk_cnt("lw_cnt", 3'd4);

    // sw then jal
    fetch_decode("sw", 32'h00202223);
    cyc("sw_exec", 1'b0, 32'h0, 1'b0, pk(0,0,0,3'b000,0,1,3'b001,0,0,2'b00));
    cyc("sw_memwait", 1'b0, 32'h0, 1'b0, pk(1,1,0,3'b000,0,1,3'b000,0,0,2'b00));
    cyc("sw_memrdy", 1'b1, 32'h0, 1'b0, pk(1,1,0,3'b000,0,1,3'b000,0,1,2'b00));
    chk_cnt("sw_cnt", 3'd5);
    fetch_decode("jal", 32'h000000EF);
    cyc("jal_exec", 1'b0, 32'h0, 1'b0, pk(0,0,1,3'b000,0,0,3'b100,1,1,2'b10));
    chk_cnt("jal_cnt", 3'd6);

    // sub (R-type, instr[30]=1)
    fetch_decode("sub", 32'h402081B3);
    cyc("sub_exec", 1'b0, 32'h0, 1'b0, pk(0,0,0,3'b000,1,0,3'b000,0,0,2'b00));
    cyc("sub_wb", 1'b0, 32'h0, 1'b0, C_WB_ALU);
    chk_cnt("sub_cnt", 3'd7);

    // lui: eighth retirement wraps the 3-bit counter
    fetch_decode("lui", 32'h123452B7);
    cyc("lui_exec", 1'b0, 32'h0, 1'b0, pk(0,0,1,3'b000,0,0,3'b010,0,1,2'b11));
    chk_cnt("wrap_cnt", 3'd0);

    // ready arrives on the 5th FETCH cycle: no trap
    for (int i = 0; i < 4; i++) cyc("fetch_wait", 1'b0, 32'h0, 1'b0, C_F);
    fetch_decode("andi", 32'h0070F093);
    cyc("andi_exec", 1'b0, 32'h0, 1'b0, pk(0,0,0,3'b111,0,1,3'b000,0,0,2'b00));
    cyc("andi_wb", 1'b0, 32'h0, 1'b0, C_WB_ALU);
    chk("no_timeout", {31'b0, timeout}, 32'h0);
    chk_cnt("andi_cnt", 3'd1);

    // illegal opcode -> absorbing TRAP
    fetch_decode("ill", 32'hFFFFFFFF);
    chk("illegal_set", {31'b0, illegal}, 32'h1);
    for (int i = 0; i < 20; i++) cyc("trap_hold", 1'b1, $urandom, 1'b1, 15'd0);
    chk("trap_instr", instr, 32'hFFFFFFFF);
    chk_cnt("trap_cnt", 3'd1);
    chk("trap_flags", {30'b0, illegal, timeout}, 32'h2);

    // async reset in the middle of a load's MEM wait
    rst = 1'b1; #1;
    chk("rst2_flags", {30'b0, illegal, timeout}, 32'h0);
    @(negedge clk); rst = 1'b0;
    fetch_decode("addi2", 32'h00500093);
    cyc("addi2_exec", 1'b0, 32'h0, 1'b0, pk(0,0,0,3'b000,0,1,3'b000,0,0,2'b00));
    cyc("addi2_wb", 1'b0, 32'h0, 1'b0, C_WB_ALU);
    fetch_decode("lw2", 32'h00002103);
    cyc("lw2_exec", 1'b0, 32'h0, 1'b0, pk(0,0,0,3'b000,0,1,3'b000,0,0,2'b00));
    mem_ready = 1'b0; #1;
    chk("lw2_mem", {17'b0, ctl_o}, {17'b0, pk(1,0,0,3'b000,0,1,3'b000,0,0,2'b00)});
    chk_cnt("pre_rst_cnt", 3'd1);
    #2 rst = 1'b1; #1;
    chk("midrst_ctl", {17'b0, ctl_o}, 32'h0);
    chk_cnt("midrst_cnt", 3'd0);
    chk("midrst_instr", instr, 32'h0);
    @(negedge clk); rst = 1'b0;

    // ready never arrives: trap after 5 FETCH cycles
    for (int i = 0; i < 5; i++) cyc("to_fetch", 1'b0, 32'h0, 1'b0, C_F);
    chk("timeout_set", {31'b0, timeout}, 32'h1);
    cyc("to_trap", 1'b1, 32'h12345678, 1'b0, 15'd0);
    cyc("to_trap2", 1'b1, 32'h12345678, 1'b0, 15'd0);
    chk("to_instr", instr, 32'h0);
    chk("to_illegal", {31'b0, illegal}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
